led_pwm_driver: RTL and testbench

LED_PWM_DRIVER -- requirements
Module: led_pwm_driver

---
 rtl/led_pwm_driver.sv | 96 +++++++++
 tb/tb_led_pwm_driver.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_driver.sv
// rtl/led_pwm_driver.sv - 8-bit PWM dimming plus blink gating for 32 active-low LEDs
// Duty changes are double-buffered so a new level only takes effect at a PWM period boundary.
module led_pwm_driver #(
  parameter logic [31:0] ADDR_CTRL  = 32'h0000_7f38,
  parameter logic [31:0] ADDR_BLINK = 32'h0000_7f3c
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] led_in,
  input  logic [31:0] ADD_I,
  input  logic        WE_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic [31:0] led_out
);

  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_shadow;
  logic [7:0]  duty_active;
  logic        blink_en;
  logic [23:0] half_period;
  logic [23:0] blink_cnt;
  logic        blink_phase;

  logic wr_ctrl;
  logic wr_blink;
  logic blink_restart;
  logic blink_run;
  logic pwm_on;
  logic pending;
  logic unused_dat;

  assign wr_ctrl       = WE_I && (ADD_I == ADDR_CTRL);
  assign wr_blink      = WE_I && (ADD_I == ADDR_BLINK);
  assign blink_restart = wr_blink || (wr_ctrl && (DAT_I[8] != blink_en));
  assign blink_run     = blink_en && (half_period != 24'd0);
  assign pwm_on        = (duty_active == 8'hFF) || (pwm_cnt < duty_active);
  assign pending       = (duty_shadow != duty_active);
  assign unused_dat    = ^DAT_I[31:24];

  always_comb begin
    DAT_O = 32'h0;
    if (ADD_I == ADDR_CTRL) begin
      DAT_O = {15'd0, pending, 7'd0, blink_en, duty_shadow};
    end else if (ADD_I == ADDR_BLINK) begin
      DAT_O = {8'd0, half_period};
    end
  end

  // duty_active samples the pre-edge shadow, so a write on the wrap edge waits a full period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt     <= 8'h00;
      duty_shadow <= 8'hFF;
      duty_active <= 8'hFF;
      blink_en    <= 1'b0;
      half_period <= 24'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) begin
        duty_active <= duty_shadow;
      end
      if (wr_ctrl) begin
        duty_shadow <= DAT_I[7:0];
        blink_en    <= DAT_I[8];
      end
      if (wr_blink) begin
        half_period <= DAT_I[23:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt   <= 24'd0;
      blink_phase <= 1'b1;
    end else if (blink_restart || !blink_run) begin
      blink_cnt   <= 24'd0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == half_period - 24'd1) begin
      blink_cnt   <= 24'd0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= 32'hFFFF_FFFF;
    end else begin
      led_out <= ~(~led_in & {32{pwm_on & blink_phase}});
    end
  end

endmodule

// File: tb/tb_led_pwm_driver.sv
// tb/tb_led_pwm_driver.sv - randomized bench for led_pwm_driver against a cycle-count reference model
module tb_led_pwm_driver;

  localparam logic [31:0] A_CTRL  = 32'h0000_7f38;
  localparam logic [31:0] A_BLINK = 32'h0000_7f3c;
  localparam logic [31:0] A_LO    = 32'h0000_7f34;
  localparam logic [31:0] A_HI    = 32'h0000_7f40;

  logic        clk;
  logic        reset;
  logic [31:0] led_in;
  logic [31:0] ADD_I;
  logic        WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic [31:0] led_out;

  int n_tests;
  int n_fail;

  // reference state: edges since reset release, and the edge at which blink counting restarted
  int          m_tick;
  int          m_bstart;
  logic [7:0]  m_shadow;
  logic [7:0]  m_act;
  logic        m_en;
  logic [23:0] m_hp;
  logic [31:0] m_led;

  led_pwm_driver dut (
    .clk    (clk),
    .reset  (reset),
    .led_in (led_in),
    .ADD_I  (ADD_I),
    .WE_I   (WE_I),
    .DAT_I  (DAT_I),
    .DAT_O  (DAT_O),
    .led_out(led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_phase();
    if (!m_en || m_hp == 24'd0) return 1'b1;
    return (((m_tick - m_bstart) / int'(m_hp)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == A_CTRL)  return {15'd0, (m_shadow != m_act), 7'd0, m_en, m_shadow};
    if (a == A_BLINK) return {8'd0, m_hp};
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_tick   = 0;
    m_bstart = 0;
    m_shadow = 8'hFF;
    m_act    = 8'hFF;
    m_en     = 1'b0;
    m_hp     = 24'd0;
    m_led    = 32'hFFFF_FFFF;
  endtask

  task automatic step();
    logic ph;
    logic on;
    @(posedge clk);
    if (reset) begin
      ph = m_phase();
      on = (m_act == 8'hFF) || ((m_tick % 256) < int'(m_act));
      m_led = ~(~led_in & {32{on & ph}});
      if (m_tick % 256 == 255) m_act = m_shadow;
      if (WE_I && ADD_I == A_CTRL) begin
        if (DAT_I[8] != m_en) m_bstart = m_tick + 1;
        m_shadow = DAT_I[7:0];
        m_en     = DAT_I[8];
      end else if (WE_I && ADD_I == A_BLINK) begin
        m_hp     = DAT_I[23:0];
        m_bstart = m_tick + 1;
      end
      m_tick++;
    end
    #1;
  endtask

  task automatic do_reset();
    WE_I  = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    WE_I   = 1'b0;
    led_in = 32'h0;
    ADD_I  = A_CTRL;
    DAT_I  = 32'h0;
    reset  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (led_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_led: got %h expected ffffffff", led_out); end
    n_tests++;
    if (DAT_O !== 32'h0000_00FF) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 000000ff", DAT_O); end
    ADD_I = A_BLINK;
    #1;
    n_tests++;
    if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL reset_blink: got %h expected 00000000", DAT_O); end
    WE_I  = 1'b1;
    ADD_I = A_CTRL;
    DAT_I = 32'h0000_0123;
    @(posedge clk);
    #1;
    WE_I = 1'b0;
    n_tests++;
    if (DAT_O !== 32'h0000_00FF) begin n_fail++; $display("FAIL reset_write_ignored: got %h expected 000000ff", DAT_O); end
    reset = 1'b1;
  endtask

  task automatic test_static();
    led_in = 32'hFFFF_FFFE;
    ADD_I  = A_CTRL;
    #1;
    n_tests++;
    if (DAT_O !== 32'h0000_00FF) begin n_fail++; $display("FAIL static_ctrl: got %h expected 000000ff", DAT_O); end
    for (int i = 0; i < 300; i++) begin
      step();
      n_tests++;
      if (led_out !== 32'hFFFF_FFFE || led_out !== m_led) begin
        n_fail++; $display("FAIL static_led cycle %0d: got %h expected fffffffe", i, led_out);
      end
    end
  endtask

  task automatic test_duty();
    int lows;
    int guard;
    led_in = 32'hFFFF_FFFE;
    WE_I   = 1'b1;
    ADD_I  = A_CTRL;
    DAT_I  = 32'h0000_0040;
    step();
    WE_I = 1'b0;
    n_tests++;
    if (DAT_O !== 32'h0001_0040) begin n_fail++; $display("FAIL duty_pending_set: got %h expected 00010040", DAT_O); end
    guard = 0;
    while (DAT_O[16] === 1'b1 && guard < 300) begin
      step();
      n_tests++;
      if (DAT_O !== m_read(A_CTRL) || led_out !== m_led) begin
        n_fail++; $display("FAIL duty_wait: got ctrl %h led %h expected ctrl %h led %h", DAT_O, led_out, m_read(A_CTRL), m_led);
      end
      guard++;
    end
    n_tests++;
    if (guard >= 300) begin n_fail++; $display("FAIL duty_pending_clear: got pending=1 expected 0 within 300 cycles"); end
    lows = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (led_out[0] === 1'b0) lows++;
    end
    n_tests++;
    if (lows !== 64) begin n_fail++; $display("FAIL duty_low_count: got %0d expected 64", lows); end
  endtask

  task automatic test_wrap_write();
    int guard;
    WE_I  = 1'b0;
    ADD_I = A_CTRL;
    guard = 0;
    while (m_tick % 256 != 255 && guard < 300) begin
      step();
      guard++;
    end
    WE_I  = 1'b1;
    DAT_I = 32'h0000_0080;
    step();
    WE_I = 1'b0;
    n_tests++;
    if (DAT_O !== 32'h0001_0080) begin n_fail++; $display("FAIL wrap_write_pending: got %h expected 00010080", DAT_O); end
    repeat (255) step();
    n_tests++;
    if (DAT_O[16] !== 1'b1) begin n_fail++; $display("FAIL wrap_write_hold: got %b expected 1", DAT_O[16]); end
    step();
    n_tests++;
    if (DAT_O !== 32'h0000_0080) begin n_fail++; $display("FAIL wrap_write_load: got %h expected 00000080", DAT_O); end
  endtask

  task automatic test_zero_duty();
    int guard;
    WE_I  = 1'b1;
    ADD_I = A_CTRL;
    DAT_I = 32'h0;
    step();
    WE_I  = 1'b0;
    guard = 0;
    while (m_act != 8'h00 && guard < 300) begin
      step();
      guard++;
    end
    step();
    for (int i = 0; i < 300; i++) begin
      led_in = $urandom;
      step();
      n_tests++;
      if (led_out !== 32'hFFFF_FFFF || led_out !== m_led) begin
        n_fail++; $display("FAIL zero_duty cycle %0d: got %h expected ffffffff", i, led_out);
      end
    end
  endtask

  task automatic test_bad_addr();
    logic [31:0] ctrl_exp;
    logic [31:0] blink_exp;
    logic [31:0] bad [2];
    bad[0]    = A_LO;
    bad[1]    = A_HI;
    ctrl_exp  = m_read(A_CTRL);
    blink_exp = m_read(A_BLINK);
    for (int i = 0; i < 2; i++) begin
      WE_I  = 1'b0;
      ADD_I = bad[i];
      #1;
      n_tests++;
      if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL bad_addr_read %h: got %h expected 00000000", bad[i], DAT_O); end
      WE_I  = 1'b1;
      DAT_I = $urandom;
      step();
    end
    WE_I  = 1'b0;
    ADD_I = A_CTRL;
    #1;
    n_tests++;
    if (DAT_O !== ctrl_exp) begin n_fail++; $display("FAIL bad_addr_ctrl: got %h expected %h", DAT_O, ctrl_exp); end
    ADD_I = A_BLINK;
    #1;
    n_tests++;
    if (DAT_O !== blink_exp) begin n_fail++; $display("FAIL bad_addr_blink: got %h expected %h", DAT_O, blink_exp); end
  endtask

  task automatic test_blink();
    logic exp0;
    do_reset();
    led_in = $urandom & 32'hFFFF_FFFE;
    WE_I   = 1'b1;
    ADD_I  = A_CTRL;
    DAT_I  = 32'h0000_01FF;
    step();
    ADD_I = A_BLINK;
    DAT_I = 32'd10;
    step();
    WE_I = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      led_in = $urandom & 32'hFFFF_FFFE;
      step();
      exp0 = (((i - 1) / 10) % 2) == 1;
      n_tests++;
      if (led_out[0] !== exp0 || led_out !== m_led) begin
        n_fail++; $display("FAIL blink cycle %0d: got %h expected bit0=%b word %h", i, led_out, exp0, m_led);
      end
    end
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 3000; i++) begin
      led_in = $urandom;
      op     = $urandom_range(0, 9);
      WE_I   = 1'b0;
      DAT_I  = $urandom;
      case (op)
        0, 1: begin WE_I = 1'b1; ADD_I = A_CTRL; end
        2: begin
          WE_I  = 1'b1;
          ADD_I = A_BLINK;
          DAT_I = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 12));
        end
        3: begin WE_I = 1'b1; ADD_I = ($urandom_range(0, 1) == 0) ? A_LO : A_HI; end
        4: ADD_I = A_BLINK;
        5: ADD_I = $urandom;
        default: ADD_I = A_CTRL;
      endcase
      #1;
      n_tests++;
      if (DAT_O !== m_read(ADD_I)) begin
        n_fail++; $display("FAIL random_read cycle %0d addr %h: got %h expected %h", i, ADD_I, DAT_O, m_read(ADD_I));
      end
      step();
      n_tests++;
      if (led_out !== m_led) begin
        n_fail++; $display("FAIL random_led cycle %0d: got %h expected %h", i, led_out, m_led);
      end
    end
    WE_I = 1'b0;
  endtask

  task automatic test_reset_mid_blink();
    led_in = 32'h0;
    WE_I   = 1'b1;
    ADD_I  = A_CTRL;
    DAT_I  = 32'h0000_01FF;
    step();
    ADD_I = A_BLINK;
    DAT_I = 32'd5;
    step();
    WE_I = 1'b0;
    repeat (17) step();
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (led_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL async_reset_led: got %h expected ffffffff", led_out); end
    ADD_I = A_CTRL;
    #1;
    n_tests++;
    if (DAT_O !== 32'h0000_00FF) begin n_fail++; $display("FAIL async_reset_ctrl: got %h expected 000000ff", DAT_O); end
    ADD_I = A_BLINK;
    #1;
    n_tests++;
    if (DAT_O !== 32'h0) begin n_fail++; $display("FAIL async_reset_blink: got %h expected 00000000", DAT_O); end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    WE_I  = 1'b1;
    ADD_I = A_CTRL;
    DAT_I = 32'h0000_0010;
    step();
    WE_I = 1'b0;
    for (int i = 0; i < 300; i++) begin
      led_in = $urandom;
      step();
      n_tests++;
      if (led_out !== m_led) begin
        n_fail++; $display("FAIL post_reset_led cycle %0d: got %h expected %h", i, led_out, m_led);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_static();
    test_duty();
    test_wrap_write();
    test_zero_duty();
    test_bad_addr();
    test_blink();
    test_random();
    test_reset_mid_blink();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
